spi_pattern_loader: RTL and testbench

- SPI slave front end placed directly upstream of the pattern FIFO and pattern generator.
- Receives 24-bit command frames from an external SPI master, synchronised into the clk domain.
- Writes 16-bit pattern words into the FIFO.
- Holds the generator's send_speed register and pg_control level.
- Returns a status byte on MISO during every frame.

---
 rtl/spi_pattern_loader.sv | 141 ++++++++++++++
 tb/tb_spi_pattern_loader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/spi_pattern_loader.sv
// SPI mode-0 slave that turns 24-bit command frames into pattern-FIFO writes and generator controls.
// Registered outputs; a write strobe follows the cycle that sees the 24th synchronised sclk rise.
module spi_pattern_loader #(
    parameter logic [15:0] SPEED_RESET = 16'd0,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic        fifo_full,
    output logic        fifo_wr_req,
    output logic [15:0] fifo_wr_data,
    output logic        fifo_clear,
    output logic [15:0] send_speed,
    output logic        pg_control,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, SHIFT, EXEC, WAIT_CS} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_d, cs_d;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

    // cs_n chain resets low so a select already asserted at reset release never looks like a new fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            cs_d      <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    state_t      state;
    logic [4:0]  cnt;
    logic [23:0] shreg;
    logic [7:0]  status;
    logic [23:0] frame_next;
    logic [7:0]  status_now;
    logic        last_bit;

    assign frame_next = {shreg[22:0], mosi_s};
    assign status_now = {5'b0, fifo_full, overflow, pg_control};
    assign last_bit   = sclk_rise && (cnt == 5'd23);

    // Commands are decoded on the edge that captures bit 24, so their effects are visible during EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            shreg        <= '0;
            status       <= '0;
            spi_miso     <= 1'b0;
            fifo_wr_req  <= 1'b0;
            fifo_wr_data <= '0;
            fifo_clear   <= 1'b0;
            send_speed   <= SPEED_RESET;
            pg_control   <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            fifo_wr_req <= 1'b0;
            fifo_clear  <= 1'b0;
            case (state)
                IDLE: begin
                    spi_miso <= 1'b0;
                    if (cs_fall) begin
                        state    <= SHIFT;
                        cnt      <= '0;
                        shreg    <= '0;
                        status   <= status_now;
                        spi_miso <= status_now[7];
                    end
                end
                SHIFT: begin
                    if (last_bit) begin
                        state    <= EXEC;
                        shreg    <= frame_next;
                        cnt      <= cnt + 5'd1;
                        spi_miso <= 1'b0;
                        case (frame_next[23:16])
                            8'h01: begin
                                if (!fifo_full) begin
                                    fifo_wr_req  <= 1'b1;
                                    fifo_wr_data <= frame_next[15:0];
                                end else begin
                                    overflow <= 1'b1;
                                end
                            end
                            8'h02: send_speed <= frame_next[15:0];
                            8'h03: pg_control <= frame_next[0];
                            8'h04: fifo_clear <= 1'b1;
                            8'h05: overflow   <= 1'b0;
                            default: ;
                        endcase
                    end else if (cs_rise) begin
                        state    <= IDLE;
                        spi_miso <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            shreg <= frame_next;
                            cnt   <= cnt + 5'd1;
                        end
                        if (sclk_fall) begin
                            spi_miso <= (cnt < 5'd8) ? status[3'd7 - cnt[2:0]] : 1'b0;
                        end
                    end
                end
                EXEC: begin
                    spi_miso <= 1'b0;
                    state    <= cs_s ? IDLE : WAIT_CS;
                end
                WAIT_CS: begin
                    spi_miso <= 1'b0;
                    if (cs_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_pattern_loader.sv
// Directed plus randomized frames against a command-level model of the loader.
module tb_spi_pattern_loader;

    localparam logic [15:0] SPEED_RESET = 16'h0007;
    localparam int          SYNC_STAGES = 2;
    localparam int          HALF        = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        fifo_full = 1'b0;
    logic        fifo_wr_req;
    logic [15:0] fifo_wr_data;
    logic        fifo_clear;
    logic [15:0] send_speed;
    logic        pg_control;
    logic        overflow;

    spi_pattern_loader #(.SPEED_RESET(SPEED_RESET), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst(rst),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .fifo_full(fifo_full), .fifo_wr_req(fifo_wr_req), .fifo_wr_data(fifo_wr_data),
        .fifo_clear(fifo_clear), .send_speed(send_speed), .pg_control(pg_control),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int      checks = 0;
    int      errors = 0;
    longint  cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed strobes, gathered on the falling edge.
    logic [15:0] got_data[$];
    longint      got_cyc[$];
    int          got_clr = 0;
    logic        prev_wr = 1'b0;
    logic        prev_clr = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_wr_req) begin
                got_data.push_back(fifo_wr_data);
                got_cyc.push_back(cyc);
                check("wr_req_width", {31'd0, prev_wr}, 32'd0);
            end
            if (fifo_clear) begin
                got_clr++;
                check("clear_width", {31'd0, prev_clr}, 32'd0);
            end
        end
        prev_wr  = fifo_wr_req;
        prev_clr = fifo_clear;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Command-level model
    logic [15:0] m_speed = SPEED_RESET;
    logic        m_pg = 1'b0;
    logic        m_ovf = 1'b0;
    int          m_clr = 0;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_frame(input logic [7:0] cmd, input logic [15:0] data, input logic full,
                            input int nbits, input int rst_at, input int gap);
        logic [23:0] f;
        logic [7:0]  miso_b;
        logic [7:0]  exp_status;
        longint      last_rise;
        int          exp_wr;
        bit          complete;
        f         = {cmd, data};
        miso_b    = '0;
        last_rise = 0;
        exp_wr    = 0;
        complete  = (nbits == 24) && (rst_at < 0);
        @(negedge clk);
        fifo_full  = full;
        exp_status = {5'b0, full, m_ovf, m_pg};
        spi_cs_n   = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                wait_clk(3);
                rst = 1'b0;
                wait_clk(1);
            end
            spi_mosi = f[23-i];
            wait_clk(HALF);
            if (i < 8) miso_b[7-i] = spi_miso;
            spi_sclk  = 1'b1;
            last_rise = cyc;
            wait_clk(HALF);
            spi_sclk = 1'b0;
        end
        wait_clk(HALF);
        spi_cs_n = 1'b1;
        wait_clk(gap);

        if (rst_at >= 0) begin
            m_speed = SPEED_RESET;
            m_pg    = 1'b0;
            m_ovf   = 1'b0;
        end else if (complete) begin
            case (cmd)
                8'h01: if (!full) exp_wr = 1; else m_ovf = 1'b1;
                8'h02: m_speed = data;
                8'h03: m_pg = data[0];
                8'h04: m_clr++;
                8'h05: m_ovf = 1'b0;
                default: ;
            endcase
        end

        if (nbits >= 8 && rst_at < 0) check("miso_status", {24'd0, miso_b}, {24'd0, exp_status});
        check("send_speed", {16'd0, send_speed}, {16'd0, m_speed});
        check("pg_control", {31'd0, pg_control}, {31'd0, m_pg});
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        check("clear_count", got_clr, m_clr);
        check("miso_idle", {31'd0, spi_miso}, 32'd0);
        check("wr_count", got_data.size(), exp_wr);
        if (exp_wr == 1 && got_data.size() == 1) begin
            check("wr_data", {16'd0, got_data[0]}, {16'd0, data});
            check("wr_latency", 32'(got_cyc[0] - last_rise), 32'(SYNC_STAGES + 1));
        end
        got_data.delete();
        got_cyc.delete();
    endtask

    initial begin
        logic [7:0] cmds[6];
        logic [7:0] rc;
        int         nb;

        wait_clk(3);
        check("rst_wr_req", {31'd0, fifo_wr_req}, 32'd0);
        check("rst_speed", {16'd0, send_speed}, {16'd0, SPEED_RESET});
        rst = 1'b0;
        wait_clk(4);
        check("reset_wr_req", {31'd0, fifo_wr_req}, 32'd0);
        check("reset_wr_data", {16'd0, fifo_wr_data}, 32'd0);
        check("reset_clear", {31'd0, fifo_clear}, 32'd0);
        check("reset_speed", {16'd0, send_speed}, {16'd0, SPEED_RESET});
        check("reset_pg", {31'd0, pg_control}, 32'd0);
        check("reset_ovf", {31'd0, overflow}, 32'd0);
        check("reset_miso", {31'd0, spi_miso}, 32'd0);

        do_frame(8'h01, 16'hA5C3, 1'b0, 24, -1, 6);
        do_frame(8'h01, 16'h1234, 1'b1, 24, -1, 6);
        do_frame(8'h00, 16'h0000, 1'b1, 24, -1, 6);
        do_frame(8'h05, 16'h0000, 1'b0, 24, -1, 6);
        do_frame(8'h02, 16'h0009, 1'b0, 24, -1, 6);
        do_frame(8'h03, 16'h0001, 1'b0, 24, -1, 6);
        do_frame(8'h00, 16'h0000, 1'b0, 24, -1, 6);
        do_frame(8'h03, 16'h0000, 1'b0, 24, -1, 6);
        do_frame(8'h02, 16'hFFFF, 1'b0, 12, -1, 6);
        do_frame(8'h04, 16'h0000, 1'b0, 24, -1, 6);
        for (int k = 0; k < 4; k++) do_frame(8'h01, 16'(k), 1'b0, 24, -1, 4);
        do_frame(8'h02, 16'h00FF, 1'b0, 24, 20, 6);
        do_frame(8'h01, 16'hBEEF, 1'b0, 24, -1, 6);

        cmds = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00};
        for (int r = 0; r < 40; r++) begin
            rc = cmds[$urandom_range(0, 5)];
            if (rc == 8'h00) rc = 8'($urandom);
            nb = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 23) : 24;
            do_frame(rc, 16'($urandom), 1'($urandom_range(0, 1)), nb, -1, $urandom_range(4, 8));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
